// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order imem requests from pc_in and queues
// returned {instr, pc} pairs for decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FAULT
    } state_e;

    state_e        state_q;
    logic          fault_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [PW-1:0] qhead_q, qhead_d;
    logic [PW-1:0] qtail_q, qtail_d;
    logic [PW-1:0] thead_q, thead_d;
    logic [PW-1:0] ttail_q, ttail_d;

    logic [31:0] qinstr_q [QUEUE_DEPTH];
    logic [31:0] qpc_q    [QUEUE_DEPTH];
    logic [31:0] tag_q    [QUEUE_DEPTH];

    logic          credit;
    logic          misal;
    logic          issue_ok;
    logic          accept;
    logic          rsp;
    logic          rsp_keep;
    logic          pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Queued plus in-flight entries may never exceed the queue size
    assign credit   = ({1'b0, count_q} + {1'b0, outst_q}) < {1'b0, DEPTH};
    assign misal    = |pc_in[1:0];
    assign issue_ok = (state_q == FETCH) && !flush && credit;
    assign imem_req = issue_ok && !misal;
    assign imem_addr = pc_in;
    assign accept   = imem_req && imem_gnt;
    assign pc_advance = accept;

    assign rsp      = imem_rvalid && (outst_q != '0);
    assign rsp_keep = rsp && (disc_q == '0) && !flush;
    assign id_valid = (count_q != '0);
    assign pop      = id_valid && id_ready && !flush;
    assign id_instr = id_valid ? qinstr_q[qhead_q] : RESET_INSTR;
    assign id_pc    = id_valid ? qpc_q[qhead_q] : 32'h0;
    assign fetch_fault = fault_q;

    always_comb begin
        count_d = count_q;
        outst_d = outst_q;
        disc_d  = disc_q;
        qhead_d = qhead_q;
        qtail_d = qtail_q;
        thead_d = thead_q;
        ttail_d = ttail_q;
        if (accept) ttail_d = inc(ttail_q);
        if (rsp) thead_d = inc(thead_q);
        if (accept && !rsp) outst_d = outst_q + ONE;
        else if (!accept && rsp) outst_d = outst_q - ONE;
        if (flush) begin
            count_d = '0;
            qhead_d = '0;
            qtail_d = '0;
            disc_d  = outst_d;
        end else begin
            if (rsp && disc_q != '0) disc_d = disc_q - ONE;
            if (rsp_keep) qtail_d = inc(qtail_q);
            if (pop) qhead_d = inc(qhead_q);
            if (rsp_keep && !pop) count_d = count_q + ONE;
            else if (!rsp_keep && pop) count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (issue_ok && misal) begin
                        state_q <= FAULT;
                        fault_q <= 1'b1;
                    end
                end
                FAULT: begin
                    if (flush) begin
                        state_q <= FETCH;
                        fault_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            outst_q <= '0;
            disc_q  <= '0;
            qhead_q <= '0;
            qtail_q <= '0;
            thead_q <= '0;
            ttail_q <= '0;
        end else begin
            count_q <= count_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
            qhead_q <= qhead_d;
            qtail_q <= qtail_d;
            thead_q <= thead_d;
            ttail_q <= ttail_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters
    always_ff @(posedge clk) begin
        if (accept) tag_q[ttail_q] <= pc_in;
        if (rsp_keep) begin
            qinstr_q[qtail_q] <= imem_rdata;
            qpc_q[qtail_q]    <= tag_q[thead_q];
        end
    end

endmodule
